// File: rtl/pbs_turn_ctrl_if.sv
// Turn sequencer bus: player/AI move inputs, random value, HP and result flags.
// master drives stimulus (button, moves, random); slave is the sequencer.
interface pbs_turn_ctrl_if;
  logic       go;
  logic [1:0] player_move;
  logic [1:0] ai_move;
  logic [3:0] rand_val;
  logic [7:0] player_hp;
  logic [7:0] ai_hp;
  logic       player_hit;
  logic       ai_hit;
  logic       crit;
  logic       busy;
  logic       victory;
  logic       loss;
  logic [3:0] state;

  modport master (
    output go, player_move, ai_move, rand_val,
    input  player_hp, ai_hp, player_hit, ai_hit, crit, busy, victory, loss, state
  );

  modport slave (
    input  go, player_move, ai_move, rand_val,
    output player_hp, ai_hp, player_hit, ai_hit, crit, busy, victory, loss, state
  );
endinterface

// File: rtl/pbs_turn_ctrl.sv
// Battle turn sequencer: owns both HP registers and one shared add/sub ALU, 8 busy cycles per turn.
// Define PBS_CRIT_EN to enable critical hits (latched rand == 0 doubles base power).
module pbs_turn_ctrl #(
  parameter int MAX_HP = 100
) (
  input  logic            clk,
  input  logic            reset,
  pbs_turn_ctrl_if.slave  bus
);

  localparam logic [3:0] S_WAIT_GO  = 4'd0;
  localparam logic [3:0] S_GO_WAIT  = 4'd1;
  localparam logic [3:0] S_LOAD_PM  = 4'd2;
  localparam logic [3:0] S_CALC_PH  = 4'd3;
  localparam logic [3:0] S_APPLY_AD = 4'd4;
  localparam logic [3:0] S_CHECK_AI = 4'd5;
  localparam logic [3:0] S_LOAD_AM  = 4'd6;
  localparam logic [3:0] S_CALC_AH  = 4'd7;
  localparam logic [3:0] S_APPLY_PD = 4'd8;
  localparam logic [3:0] S_CHECK_P  = 4'd9;
  localparam logic [3:0] S_VICTORY  = 4'd10;
  localparam logic [3:0] S_LOSS     = 4'd11;

  localparam logic [7:0] HP_INIT = 8'(MAX_HP);

  logic [3:0] state_q, state_d;
  logic [1:0] pm_q, am_q;
  logic [3:0] rnd_q;
  logic [7:0] dmg_q;
  logic [7:0] player_hp_q, ai_hp_q;
  logic       player_hit_q, ai_hit_q, crit_q, victory_q, loss_q;

  logic [1:0] mv_sel;
  logic [7:0] power;
  logic [3:0] acc;
  logic       hit;
  logic       is_crit;
  logic       alu_sub;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [7:0] dmg_calc;

  // Only the AI calc uses the AI move; every other state looks at the player move.
  always_comb begin
    mv_sel = (state_q == S_CALC_AH) ? am_q : pm_q;
    power  = 8'd10;
    acc    = 4'd15;
    case (mv_sel)
      2'd0: begin power = 8'd10; acc = 4'd15; end
      2'd1: begin power = 8'd15; acc = 4'd14; end
      2'd2: begin power = 8'd25; acc = 4'd10; end
      default: begin power = 8'd40; acc = 4'd6; end
    endcase
    hit = (rnd_q < acc);
  end

  // Shared ALU: add in CALC states, saturating subtract in APPLY states.
  always_comb begin
    alu_sub = 1'b0;
    alu_a   = power;
    alu_b   = {6'd0, rnd_q[1:0]};
    if (state_q == S_APPLY_AD) begin
      alu_sub = 1'b1;
      alu_a   = ai_hp_q;
      alu_b   = dmg_q;
    end else if (state_q == S_APPLY_PD) begin
      alu_sub = 1'b1;
      alu_a   = player_hp_q;
      alu_b   = dmg_q;
    end
    if (alu_sub)
      alu_res = (alu_a > alu_b) ? (alu_a - alu_b) : 8'd0;
    else
      alu_res = alu_a + alu_b;
  end

`ifdef PBS_CRIT_EN
  // rand == 0 makes the ALU add zero, so its result is the bare power to double.
  always_comb begin
    is_crit  = hit && (rnd_q == 4'd0);
    dmg_calc = is_crit ? {alu_res[6:0], 1'b0} : alu_res;
  end
`else
  always_comb begin
    is_crit  = 1'b0;
    dmg_calc = alu_res;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_GO:  if (bus.go)  state_d = S_GO_WAIT;
      S_GO_WAIT:  if (!bus.go) state_d = S_LOAD_PM;
      S_LOAD_PM:  state_d = S_CALC_PH;
      S_CALC_PH:  state_d = S_APPLY_AD;
      S_APPLY_AD: state_d = S_CHECK_AI;
      S_CHECK_AI: state_d = (ai_hp_q == 8'd0) ? S_VICTORY : S_LOAD_AM;
      S_LOAD_AM:  state_d = S_CALC_AH;
      S_CALC_AH:  state_d = S_APPLY_PD;
      S_APPLY_PD: state_d = S_CHECK_P;
      S_CHECK_P:  state_d = (player_hp_q == 8'd0) ? S_LOSS : S_WAIT_GO;
      S_VICTORY:  state_d = S_VICTORY;
      S_LOSS:     state_d = S_LOSS;
      default:    state_d = S_WAIT_GO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_WAIT_GO;
      pm_q         <= 2'd0;
      am_q         <= 2'd0;
      rnd_q        <= 4'd0;
      dmg_q        <= 8'd0;
      player_hp_q  <= HP_INIT;
      ai_hp_q      <= HP_INIT;
      player_hit_q <= 1'b0;
      ai_hit_q     <= 1'b0;
      crit_q       <= 1'b0;
      victory_q    <= 1'b0;
      loss_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_LOAD_PM: begin
          pm_q  <= bus.player_move;
          rnd_q <= bus.rand_val;
        end
        S_CALC_PH: begin
          player_hit_q <= hit;
          dmg_q        <= dmg_calc;
          crit_q       <= is_crit;
        end
        S_APPLY_AD: if (player_hit_q) ai_hp_q <= alu_res;
        S_CHECK_AI: if (ai_hp_q == 8'd0) victory_q <= 1'b1;
        S_LOAD_AM: begin
          am_q  <= bus.ai_move;
          rnd_q <= bus.rand_val;
        end
        S_CALC_AH: begin
          ai_hit_q <= hit;
          dmg_q    <= dmg_calc;
          crit_q   <= is_crit;
        end
        S_APPLY_PD: if (ai_hit_q) player_hp_q <= alu_res;
        S_CHECK_P:  if (player_hp_q == 8'd0) loss_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.player_hp  = player_hp_q;
  assign bus.ai_hp      = ai_hp_q;
  assign bus.player_hit = player_hit_q;
  assign bus.ai_hit     = ai_hit_q;
  assign bus.crit       = crit_q;
  assign bus.busy       = (state_q >= S_LOAD_PM) && (state_q <= S_CHECK_P);
  assign bus.victory    = victory_q;
  assign bus.loss       = loss_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Directed bench for pbs_turn_ctrl: reset, normal turn, miss, crit, victory, loss, mid-turn reset.
module tb_pbs_turn_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  pbs_turn_ctrl_if bus ();

  pbs_turn_ctrl #(.MAX_HP(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.go = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  // Starts from WAIT_GO, presses and releases go, then steps the 8 turn cycles.
  // Inputs are scrambled outside their LOAD cycle so only the latched values matter.
  task automatic run_turn(input logic [1:0] pm, input logic [3:0] pr,
                          input logic [1:0] am, input logic [3:0] ar,
                          output int bcnt, output int crit_p);
    bcnt   = 0;
    crit_p = 0;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      bcnt += int'(bus.busy);
      if (i == 2) crit_p = int'(bus.crit);
      bus.player_move = (i == 0) ? pm : ~pm;
      bus.ai_move     = (i == 4) ? am : ~am;
      bus.rand_val    = (i == 0) ? pr : ((i == 4) ? ar : ~pr);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bcnt;
    int critp;
    int idle_busy;

    bus.go          = 1'b0;
    bus.player_move = 2'd0;
    bus.ai_move     = 2'd0;
    bus.rand_val    = 4'd0;
    reset           = 1'b1;

    // Reset state
    do_reset();
    check("rst_state",   int'(bus.state), 0);
    check("rst_php",     int'(bus.player_hp), 100);
    check("rst_aihp",    int'(bus.ai_hp), 100);
    check("rst_flags",   int'({bus.player_hit, bus.ai_hit, bus.crit, bus.busy, bus.victory, bus.loss}), 0);
    idle_busy = 0;
    for (int i = 0; i < 10; i++) begin
      idle_busy += int'(bus.busy);
      tick();
    end
    check("idle_busy",   idle_busy, 0);
    check("idle_state",  int'(bus.state), 0);

    // Normal turn: 25+3 = 28 -> ai 72; 10+1 = 11 -> player 89
    run_turn(2'd2, 4'd3, 2'd0, 4'd1, bcnt, critp);
    check("norm_aihp",   int'(bus.ai_hp), 72);
    check("norm_php",    int'(bus.player_hp), 89);
    check("norm_phit",   int'(bus.player_hit), 1);
    check("norm_aihit",  int'(bus.ai_hit), 1);
    check("norm_busy",   bcnt, 8);
    check("norm_state",  int'(bus.state), 0);
    check("norm_crit",   critp, 0);

    // Miss: move 3 accuracy 6, rand 9 misses; AI rand 15 misses
    do_reset();
    run_turn(2'd3, 4'd9, 2'd0, 4'd15, bcnt, critp);
    check("miss_phit",   int'(bus.player_hit), 0);
    check("miss_aihit",  int'(bus.ai_hit), 0);
    check("miss_aihp",   int'(bus.ai_hp), 100);
    check("miss_php",    int'(bus.player_hp), 100);

    // Crit: move 1 rand 0
    do_reset();
    run_turn(2'd1, 4'd0, 2'd0, 4'd15, bcnt, critp);
`ifdef PBS_CRIT_EN
    check("crit_aihp",   int'(bus.ai_hp), 70);
    check("crit_flag",   critp, 1);
`else
    check("crit_aihp",   int'(bus.ai_hp), 85);
    check("crit_flag",   critp, 0);
`endif
    check("crit_clear",  int'(bus.crit), 0);

    // Victory: 40+3 = 43 per turn, 100 -> 57 -> 14 -> 0
    do_reset();
    run_turn(2'd3, 4'd3, 2'd0, 4'd15, bcnt, critp);
    check("vic_t1_aihp", int'(bus.ai_hp), 57);
    run_turn(2'd3, 4'd3, 2'd0, 4'd15, bcnt, critp);
    check("vic_t2_aihp", int'(bus.ai_hp), 14);
    check("vic_t2_vic",  int'(bus.victory), 0);
    run_turn(2'd3, 4'd3, 2'd0, 4'd15, bcnt, critp);
    check("vic_aihp",    int'(bus.ai_hp), 0);
    check("vic_state",   int'(bus.state), 10);
    check("vic_flag",    int'(bus.victory), 1);
    check("vic_loss",    int'(bus.loss), 0);
    check("vic_busy",    bcnt, 4);
    check("vic_php",     int'(bus.player_hp), 100);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    tick();
    check("vic_go_state", int'(bus.state), 10);
    check("vic_go_busy",  int'(bus.busy), 0);
    check("vic_sticky",   int'(bus.victory), 1);

    // Loss: player always misses, AI move 3 rand 3 deals 43 per turn
    do_reset();
    run_turn(2'd3, 4'd9, 2'd3, 4'd3, bcnt, critp);
    check("loss_t1_php", int'(bus.player_hp), 57);
    run_turn(2'd3, 4'd9, 2'd3, 4'd3, bcnt, critp);
    run_turn(2'd3, 4'd9, 2'd3, 4'd3, bcnt, critp);
    check("loss_php",    int'(bus.player_hp), 0);
    check("loss_state",  int'(bus.state), 11);
    check("loss_flag",   int'(bus.loss), 1);
    check("loss_vic",    int'(bus.victory), 0);
    check("loss_busy",   bcnt, 8);
    check("loss_aihp",   int'(bus.ai_hp), 100);

    // Reset mid-turn during CALC_AH
    do_reset();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    bus.player_move = 2'd2;
    bus.rand_val    = 4'd3;
    tick();
    tick();
    tick();
    tick();
    bus.ai_move  = 2'd3;
    bus.rand_val = 4'd0;
    tick();
    check("mid_state",   int'(bus.state), 7);
    check("mid_aihp",    int'(bus.ai_hp), 72);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", int'(bus.state), 0);
    check("mid_rst_aihp",  int'(bus.ai_hp), 100);
    check("mid_rst_php",   int'(bus.player_hp), 100);
    check("mid_rst_flags", int'({bus.player_hit, bus.ai_hit, bus.crit, bus.busy}), 0);
    tick();
    tick();
    check("mid_post_php",  int'(bus.player_hp), 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
